// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {instr, pc} with a fully
// registered boundary, flush on redirect, and opcode/funct field extraction for control.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [XLEN-1:0]          fetch_instr_i,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic                     flush_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [XLEN-1:0]          dec_instr_o,
  output logic [XLEN-1:0]          dec_pc_o,
  output logic [XLEN-1:0]          dec_pc_plus4_o,
  output logic [6:0]               op_o,
  output logic [2:0]               funct3_o,
  output logic                     funct7_o,
  output logic                     dec_illegal_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int NUM_OPS = 8;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  localparam logic [NUM_OPS*7-1:0] SUP_OPS = {
    7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
    7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111
  };

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          fetch_ready_reg;
  logic          push, pop, head_valid;
  logic [NUM_OPS-1:0] op_hit;

  assign head_valid = (count_reg != '0);
  assign push = fetch_valid_i & fetch_ready_reg & ~flush_i;
  assign pop  = head_valid & dec_ready_i & ~flush_i;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (flush_i) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      fetch_ready_reg <= 1'b0;
    end else begin
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      // Ready looks only at the post-edge count, so a pop never frees a slot combinationally.
      fetch_ready_reg <= (count_next < CW'(DEPTH));
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= fetch_instr_i;
      pc_mem[wr_ptr_reg]    <= fetch_pc_i;
    end
  end

  assign fetch_ready_o  = fetch_ready_reg;
  assign count_o        = count_reg;
  assign dec_valid_o    = head_valid;
  assign dec_instr_o    = head_valid ? instr_mem[rd_ptr_reg] : NOP;
  assign dec_pc_o       = head_valid ? pc_mem[rd_ptr_reg] : '0;
  assign dec_pc_plus4_o = dec_pc_o + XLEN'(4);
  assign op_o           = dec_instr_o[6:0];
  assign funct3_o       = dec_instr_o[14:12];
  assign funct7_o       = dec_instr_o[30];

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
      assign op_hit[gi] = (op_o == SUP_OPS[gi*7 +: 7]);
    end
  endgenerate

  assign dec_illegal_o = head_valid & ~(|op_hit);
endmodule
